// File: rtl/sort_pkg.sv
// Shared constants for the sorting engine and its result FIFO.
package sort_pkg;

  localparam int SORT_DATA_W    = 32;
  localparam int SORT_FRAME_LEN = 10;
  localparam int SORT_FIFO_DEPTH = 16;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int sort_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SORT_FIFO_CNT_W = sort_cnt_w(SORT_FIFO_DEPTH);

endpackage

// File: rtl/sort_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module sort_fifo_mem
  import sort_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W,
  parameter int DEPTH  = SORT_FIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sort_result_fifo.sv
// Result FIFO between the sorter and the AXI-stream read path, with frame-based sm_tlast.
// Define SORT_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module sort_result_fifo
  import sort_pkg::*;
#(
  parameter int DATA_W    = SORT_DATA_W,
  parameter int DEPTH     = SORT_FIFO_DEPTH,
  parameter int FRAME_LEN = SORT_FRAME_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     sm_tvalid,
  output logic [DATA_W-1:0]        sm_tdata,
  output logic                     sm_tlast,
  input  logic                     sm_tready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FCNT_W-1:0] fcnt;
  logic [CNT_W-1:0]  count_next;
  logic              pop;
  logic              push;

  assign pop  = sm_tvalid && sm_tready;
  // A flush wins over everything in the same cycle, so its write is discarded.
  assign push = w_en && (!full || pop) && !clr;

  sort_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (w_data),
    .raddr (rd_ptr),
    .rdata (sm_tdata)
  );

  assign sm_tvalid = !empty;
  assign sm_tlast  = sm_tvalid && (fcnt == FCNT_LAST);

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // full/empty are registered from the next occupancy so they line up with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fcnt   <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          fcnt   <= (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
        end
      end
    end
  end

`ifdef SORT_FIFO_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (w_en && full && !pop) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/sort_result_fifo.md
# sort_result_fifo

Buffers the sorted words produced by the sorting engine and returns them to the host side as an AXI-stream master. The sorter writes one word per cycle for 10 cycles, with no backpressure. This FIFO absorbs the burst, delivers the words in order on sm_*, and marks the last word of each sorted frame with sm_tlast. It sits between the sorter output (data_out / w_fifo_en) and the user-project AXI-stream read path.

## Interface
- DATA_W, 32, word width
- DEPTH, 16, entries; power of two, ≥ FRAME_LEN
- FRAME_LEN, 10, words per sorted frame; sets the sm_tlast cadence

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush, active-high
- w_en  in  1  write strobe from the sorter (w_fifo_en)
- w_data  in  DATA_W  write word from the sorter (data_out)
- sm_tvalid  out  1  output word valid
- sm_tdata  out  DATA_W  output word
- sm_tlast  out  1  last word of the current frame
- sm_tready  in  1  downstream ready
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- Storage: register array of DEPTH×DATA_W.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH.
  - Occupancy counter count, tracked separately.
- Push: occurs when w_en && (!full || pop).
  - Writes mem[wr_ptr], then wr_ptr+1.
- Pop: occurs when sm_tvalid && sm_tready.
  - rd_ptr+1.
  - Frame counter fcnt+1; fcnt wraps to 0 after FRAME_LEN-1.
- Output path is first-word-fall-through:
  - sm_tdata = mem[rd_ptr].
  - sm_tvalid = !empty.
  - sm_tlast = sm_tvalid && (fcnt == FRAME_LEN-1).
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop, or when neither occurs.
- Full with w_en and no pop: the word is dropped and pointers are unchanged.
- Full with w_en and a simultaneous pop: the write is accepted and count stays at DEPTH.
- Empty with w_en: the word is stored; sm_tvalid rises the next cycle. A pop cannot occur this cycle.
- clr:
  - Zeroes wr_ptr, rd_ptr, count, fcnt and ovf.
  - Has priority over push and pop in the same cycle; that push is dropped.
  - Memory contents are not cleared.
- AXI rule: once sm_tvalid is high, sm_tdata and sm_tlast hold stable until the pop. The pointers move only on a pop, so this holds by construction.

## Timing
- Reset (rst_n low, async) values:
  - sm_tvalid=0, sm_tlast=0, empty=1, full=0, count=0, ovf=0.
  - Pointers and fcnt = 0.
  - sm_tdata = mem[0]; memory is not reset, so the value is don't-care.
- Write-to-valid latency: 1 cycle (w_en at edge N gives sm_tvalid high after edge N).
- Sustained throughput: 1 push and 1 pop per cycle.
- A full 10-word sorter burst into an empty FIFO with sm_tready=0 occupies 10 entries; no data is lost at DEPTH=16.
- Reset asserted mid-burst: all state is discarded immediately. A frame restarts at fcnt=0 after rst_n deasserts.
- count, full, empty and ovf are all registered outputs.

## Configuration
- SORT_FIFO_OVF_EN defined:
  - ovf is set on any cycle with w_en && full && !pop && !clr.
  - ovf stays set until clr or rst_n.
- SORT_FIFO_OVF_EN undefined:
  - ovf is tied to 0 and no overflow logic is built.
  - The port remains present.
- Drop behaviour on overflow is identical in both builds.

## Structure
- Shared package sort_pkg holds:
  - SORT_DATA_W = 32 and SORT_FRAME_LEN = 10. The sorter and this block both take these as parameter defaults.
  - The localparam for the count width.
- Storage goes in one sub-module, sort_fifo_mem: a simple dual-port register array with synchronous write and asynchronous read.
- Pointer, count, frame and flag logic stays in sort_result_fifo.

## Test plan
- Reset, then write 10 words 9,3,7,… in consecutive cycles with sm_tready=0 → count=10 one cycle after the last write. Then hold sm_tready=1 → 10 words in write order over 10 cycles; sm_tlast is high only on the 10th; empty=1 afterwards.
- Streaming with sm_tready=1 throughout, 30 words written → sm_tlast on the 10th, 20th and 30th pops; count never exceeds 1.
- Fill to 16 with sm_tready=0, then w_en with word 0xDEAD → dropped, count=16, ovf=1 (macro on) or ovf=0 (macro off). Then drain → 16 original words out, 0xDEAD absent.
- Full FIFO, w_en and pop in the same cycle with word 0xBEEF → count stays 16; 0xBEEF emerges as the 16th word after the current head.
- Write 5 words, then assert clr together with w_en → empty=1, count=0, ovf=0, fcnt=0. The next 10 writes produce sm_tlast on the 10th.
- Assert rst_n low mid-drain (3 of 10 popped) → sm_tvalid drops asynchronously and count=0. A new 10-word frame gives sm_tlast on its 10th word.
